// File: rtl/stack_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// stack_cmd_driver_if
// Purpose : bundles the button/switch inputs and the stack command bus of
//           stack_cmd_driver so the driver and its user share one handle.
// Signals :
//   btn_push/btn_pop/btn_exch/btn_clr  raw button levels (user -> driver)
//   sw[WIDTH]                          value to push      (user -> driver)
//   stk_w2/stk_w1/stk_w3               push/pop/exch command levels
//   stk_in[WIDTH]                      data to the stack
//   stk_clk                            commit pulse, stack acts on its fall
//   stk_rst                            stack clear, active low
//   depth[3]                           shadow depth 0..DEPTH
//   busy, err_over, err_under          status
// Modports:
//   master : the side that presses buttons and watches the stack bus
//   slave  : the driver itself
// ---------------------------------------------------------------------------
interface stack_cmd_driver_if #(
  parameter int WIDTH = 4
) ();

  logic             btn_push;
  logic             btn_pop;
  logic             btn_exch;
  logic             btn_clr;
  logic [WIDTH-1:0] sw;

  logic             stk_w2;
  logic             stk_w1;
  logic             stk_w3;
  logic [WIDTH-1:0] stk_in;
  logic             stk_clk;
  logic             stk_rst;
  logic [2:0]       depth;
  logic             busy;
  logic             err_over;
  logic             err_under;

  modport master (
    output btn_push, btn_pop, btn_exch, btn_clr, sw,
    input  stk_w2, stk_w1, stk_w3, stk_in, stk_clk, stk_rst,
    input  depth, busy, err_over, err_under
  );

  modport slave (
    input  btn_push, btn_pop, btn_exch, btn_clr, sw,
    output stk_w2, stk_w1, stk_w3, stk_in, stk_clk, stk_rst,
    output depth, busy, err_over, err_under
  );

endinterface

// File: rtl/stack_cmd_driver.sv
// ---------------------------------------------------------------------------
// stack_cmd_driver
// Purpose : command initiator for a DEPTH-deep x WIDTH-bit push/pop/exch
//           stack. Each button press becomes at most one legal stack command:
//           one-hot command level, data, and a single stk_clk pulse whose
//           falling edge the stack samples. A shadow depth lets illegal
//           commands be refused here so they never reach the stack.
// Ports   :
//   ctl   in  system clock, rising edge
//   rst   in  asynchronous reset, active low
//   bus   slave modport of stack_cmd_driver_if:
//           btn_* / sw in, stk_w2/w1/w3, stk_in, stk_clk, stk_rst,
//           depth, busy, err_over, err_under out
// ---------------------------------------------------------------------------
module stack_cmd_driver #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic               ctl,
  input  logic               rst,
  stack_cmd_driver_if.slave  bus
);

  localparam int             CNT_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [2:0]     DEPTH_MAX = 3'(DEPTH);

  // Button bit positions inside the synchronised vectors.
  localparam int B_PUSH = 0;
  localparam int B_POP  = 1;
  localparam int B_EXCH = 2;
  localparam int B_CLR  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_WAIT_UP
  } state_t;

  typedef enum logic [1:0] {
    C_PUSH,
    C_POP,
    C_EXCH,
    C_CLR
  } cmd_t;

  logic [3:0]       w_btnRaw;
  logic [3:0]       r_btnMeta;
  logic [3:0]       r_btnSync;
  logic [3:0]       r_btnPrev;
  logic [3:0]       w_btnEdge;

  state_t           r_state;
  state_t           w_stateNext;
  cmd_t             r_cmd;
  cmd_t             w_cmdNext;
  logic [CNT_W-1:0] r_holdCnt;
  logic [CNT_W-1:0] w_holdNext;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_dataNext;
  logic [2:0]       r_depth;
  logic [2:0]       w_depthNext;
  logic             r_errOver;
  logic             w_errOverNext;
  logic             r_errUnder;
  logic             w_errUnderNext;

  logic             r_stkW2;
  logic             r_stkW1;
  logic             r_stkW3;
  logic             r_stkClk;
  logic             r_stkRst;
  logic             r_busy;
  logic             w_stkW2Next;
  logic             w_stkW1Next;
  logic             w_stkW3Next;
  logic             w_stkClkNext;
  logic             w_stkRstNext;
  logic             w_busyNext;
  logic             w_active;

  assign w_btnRaw = {bus.btn_clr, bus.btn_exch, bus.btn_pop, bus.btn_push};

  // Buttons are asynchronous to ctl, so they pass through two flops before
  // anything looks at them. A third flop remembers the previous synced level
  // so only a 0->1 transition counts as a press; holding a button does nothing.
  always_ff @(posedge ctl or negedge rst) begin
    if (!rst) begin
      r_btnMeta <= '0;
      r_btnSync <= '0;
      r_btnPrev <= '0;
    end else begin
      r_btnMeta <= w_btnRaw;
      r_btnSync <= r_btnMeta;
      r_btnPrev <= r_btnSync;
    end
  end

  assign w_btnEdge = r_btnSync & ~r_btnPrev;

  // State register for the command sequencer.
  always_ff @(posedge ctl or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and next-output logic. Commands are only accepted in IDLE, in
  // priority clr > push > pop > exch, so edges during a command are simply
  // lost. Legality is judged against the shadow depth before anything is
  // driven: a refused command sets its sticky error and jumps to WAIT_UP so
  // stk_clk never moves. The depth changes on the STROBE->RELEASE step, i.e.
  // together with the stk_clk fall that commits the command in the stack.
  // Outputs are decoded from the next state and registered, which keeps the
  // stack-facing lines glitch free and lets async reset clear them at once.
  always_comb begin
    w_stateNext    = r_state;
    w_cmdNext      = r_cmd;
    w_holdNext     = r_holdCnt;
    w_dataNext     = r_data;
    w_depthNext    = r_depth;
    w_errOverNext  = r_errOver;
    w_errUnderNext = r_errUnder;

    case (r_state)
      S_IDLE: begin
        if (w_btnEdge[B_CLR]) begin
          w_cmdNext      = C_CLR;
          w_dataNext     = bus.sw;
          w_errOverNext  = 1'b0;
          w_errUnderNext = 1'b0;
          w_stateNext    = S_SETUP;
        end else if (w_btnEdge[B_PUSH]) begin
          if (r_depth == DEPTH_MAX) begin
            w_errOverNext = 1'b1;
            w_stateNext   = S_WAIT_UP;
          end else begin
            w_cmdNext      = C_PUSH;
            w_dataNext     = bus.sw;
            w_errOverNext  = 1'b0;
            w_errUnderNext = 1'b0;
            w_stateNext    = S_SETUP;
          end
        end else if (w_btnEdge[B_POP]) begin
          if (r_depth == 3'd0) begin
            w_errUnderNext = 1'b1;
            w_stateNext    = S_WAIT_UP;
          end else begin
            w_cmdNext      = C_POP;
            w_dataNext     = bus.sw;
            w_errOverNext  = 1'b0;
            w_errUnderNext = 1'b0;
            w_stateNext    = S_SETUP;
          end
        end else if (w_btnEdge[B_EXCH]) begin
          if (r_depth < 3'd2) begin
            w_errUnderNext = 1'b1;
            w_stateNext    = S_WAIT_UP;
          end else begin
            w_cmdNext      = C_EXCH;
            w_dataNext     = bus.sw;
            w_errOverNext  = 1'b0;
            w_errUnderNext = 1'b0;
            w_stateNext    = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        w_holdNext  = '0;
        w_stateNext = S_STROBE;
      end

      S_STROBE: begin
        if (r_holdCnt == HOLD_LAST) begin
          w_stateNext = S_RELEASE;
          case (r_cmd)
            C_PUSH:  w_depthNext = r_depth + 3'd1;
            C_POP:   w_depthNext = r_depth - 3'd1;
            C_CLR:   w_depthNext = 3'd0;
            default: w_depthNext = r_depth;
          endcase
        end else begin
          w_holdNext = r_holdCnt + 1'b1;
        end
      end

      S_RELEASE: begin
        w_stateNext = S_WAIT_UP;
      end

      S_WAIT_UP: begin
        if (r_btnSync == 4'd0) begin
          w_stateNext = S_IDLE;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    w_active     = (w_stateNext == S_SETUP) || (w_stateNext == S_STROBE) ||
                   (w_stateNext == S_RELEASE);
    w_stkW2Next  = w_active && (w_cmdNext == C_PUSH);
    w_stkW1Next  = w_active && (w_cmdNext == C_POP);
    w_stkW3Next  = w_active && (w_cmdNext == C_EXCH);
    w_stkRstNext = !(w_active && (w_cmdNext == C_CLR));
    w_stkClkNext = (w_stateNext == S_STROBE);
    w_busyNext   = (w_stateNext != S_IDLE);
  end

  // Datapath and output registers. stk_rst idles high; everything else idles
  // low, and reset forces that immediately so a half-finished strobe is cut.
  always_ff @(posedge ctl or negedge rst) begin
    if (!rst) begin
      r_cmd      <= C_PUSH;
      r_holdCnt  <= '0;
      r_data     <= '0;
      r_depth    <= 3'd0;
      r_errOver  <= 1'b0;
      r_errUnder <= 1'b0;
      r_stkW2    <= 1'b0;
      r_stkW1    <= 1'b0;
      r_stkW3    <= 1'b0;
      r_stkClk   <= 1'b0;
      r_stkRst   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_cmd      <= w_cmdNext;
      r_holdCnt  <= w_holdNext;
      r_data     <= w_dataNext;
      r_depth    <= w_depthNext;
      r_errOver  <= w_errOverNext;
      r_errUnder <= w_errUnderNext;
      r_stkW2    <= w_stkW2Next;
      r_stkW1    <= w_stkW1Next;
      r_stkW3    <= w_stkW3Next;
      r_stkClk   <= w_stkClkNext;
      r_stkRst   <= w_stkRstNext;
      r_busy     <= w_busyNext;
    end
  end

  assign bus.stk_w2    = r_stkW2;
  assign bus.stk_w1    = r_stkW1;
  assign bus.stk_w3    = r_stkW3;
  assign bus.stk_in    = r_data;
  assign bus.stk_clk   = r_stkClk;
  assign bus.stk_rst   = r_stkRst;
  assign bus.depth     = r_depth;
  assign bus.busy      = r_busy;
  assign bus.err_over  = r_errOver;
  assign bus.err_under = r_errUnder;

endmodule

// File: tb/tb_stack_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_stack_cmd_driver
// Purpose : drives button presses into stack_cmd_driver and compares every
//           stk_clk commit, the shadow depth and the error flags with a small
//           stack-rules model kept here.
// ---------------------------------------------------------------------------
module tb_stack_cmd_driver;

  localparam int HOLD   = 2;
  localparam int K_NONE = 0;
  localparam int K_PUSH = 1;
  localparam int K_POP  = 2;
  localparam int K_EXCH = 3;
  localparam int K_CLR  = 4;

  typedef struct {
    logic       w2;
    logic       w1;
    logic       w3;
    logic [3:0] data;
    logic       srst;
    int         hi;
  } commit_t;

  logic    ctl = 1'b0;
  logic    rst = 1'b0;
  int      tests = 0;
  int      fails = 0;

  int      mDepth = 0;
  bit      mErrO = 1'b0;
  bit      mErrU = 1'b0;

  commit_t commitQ[$];
  int      hiCnt = 0;
  logic    prevClk = 1'b0;

  stack_cmd_driver_if #(.WIDTH(4)) bus ();

  stack_cmd_driver #(
    .DEPTH    (4),
    .WIDTH    (4),
    .HOLD_CYC (HOLD)
  ) dut (
    .ctl (ctl),
    .rst (rst),
    .bus (bus)
  );

  always #5 ctl = ~ctl;

  // Record every stk_clk fall seen outside reset, with the command lines,
  // data and stk_rst present at that instant and how long the pulse lasted.
  always @(negedge ctl) begin : monitor
    commit_t c;
    if (!rst) begin
      hiCnt   = 0;
      prevClk = 1'b0;
    end else begin
      if (bus.stk_clk === 1'b1) begin
        hiCnt++;
      end else if (prevClk === 1'b1) begin
        c.w2   = bus.stk_w2;
        c.w1   = bus.stk_w1;
        c.w3   = bus.stk_w3;
        c.data = bus.stk_in;
        c.srst = bus.stk_rst;
        c.hi   = hiCnt;
        commitQ.push_back(c);
        hiCnt  = 0;
      end
      prevClk = bus.stk_clk;
    end
  end

  // Stack rules: which command a press becomes and what it does to depth/errors.
  task automatic modelPress(input logic [3:0] mask, output int kind);
    kind = K_NONE;
    if (mask[3]) begin
      kind = K_CLR; mDepth = 0; mErrO = 0; mErrU = 0;
    end else if (mask[0]) begin
      if (mDepth == 4) mErrO = 1;
      else begin kind = K_PUSH; mDepth++; mErrO = 0; mErrU = 0; end
    end else if (mask[1]) begin
      if (mDepth == 0) mErrU = 1;
      else begin kind = K_POP; mDepth--; mErrO = 0; mErrU = 0; end
    end else if (mask[2]) begin
      if (mDepth < 2) mErrU = 1;
      else begin kind = K_EXCH; mErrO = 0; mErrU = 0; end
    end
  endtask

  // Expected {w2,w1,w3,stk_rst} at the commit fall for a command kind.
  function automatic logic [3:0] expLines(input int kind);
    case (kind)
      K_PUSH:  return 4'b1001;
      K_POP:   return 4'b0101;
      K_EXCH:  return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic setButtons(input logic [3:0] mask);
    bus.btn_push = mask[0];
    bus.btn_pop  = mask[1];
    bus.btn_exch = mask[2];
    bus.btn_clr  = mask[3];
  endtask

  task automatic applyReset();
    setButtons(4'b0000);
    rst = 1'b0;
    repeat (3) @(posedge ctl);
    #1 rst = 1'b1;
    repeat (2) @(posedge ctl);
    #1;
    commitQ.delete();
    mDepth = 0; mErrO = 0; mErrU = 0;
  endtask

  // Press a button set with value val, hold it holdCyc cycles after the
  // driver goes busy, release it and wait for the driver to go idle.
  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] val,
                               input int holdCyc, output bit tmo);
    int n;
    tmo = 0;
    bus.sw = val;
    setButtons(mask);
    n = 0;
    while (bus.busy !== 1'b1 && n < 20) begin @(posedge ctl); #1; n++; end
    if (n >= 20) tmo = 1;
    repeat (holdCyc) @(posedge ctl);
    #1 setButtons(4'b0000);
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(posedge ctl); #1; n++; end
    if (n >= 100) tmo = 1;
    repeat (3) @(posedge ctl);
    #1;
  endtask

  task automatic test_reset();
    setButtons(4'b0000);
    bus.sw = 4'h0;
    rst = 1'b0;
    repeat (2) @(posedge ctl);
    #1;
    tests++;
    if ({bus.stk_w2, bus.stk_w1, bus.stk_w3, bus.stk_clk, bus.busy,
         bus.err_over, bus.err_under} !== 7'b0) begin
      fails++; $display("[TB] FAIL reset_outputs got %b want 0000000",
        {bus.stk_w2, bus.stk_w1, bus.stk_w3, bus.stk_clk, bus.busy, bus.err_over, bus.err_under});
    end
    tests++;
    if (bus.stk_rst !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_stk_rst got %b want 1", bus.stk_rst);
    end
    tests++;
    if ({bus.depth, bus.stk_in} !== 7'b0) begin
      fails++; $display("[TB] FAIL reset_depth_data got %h/%h want 0/0", bus.depth, bus.stk_in);
    end
    applyReset();
  endtask

  task automatic test_push_fill();
    logic [3:0] vals [4];
    int  kind;
    bit  tmo;
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'h9; vals[3] = 4'hA;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      modelPress(4'b0001, kind);
      applyStimulus(4'b0001, vals[i], 2, tmo);
      tests++;
      if (tmo) begin fails++; $display("[TB] FAIL push_fill_timeout got busy stuck want release"); end
      tests++;
      if (commitQ.size() != 1) begin
        fails++; $display("[TB] FAIL push_fill_commits got %0d want 1", commitQ.size());
      end else begin
        tests++;
        if ({commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst} !== expLines(kind) ||
            commitQ[0].data !== vals[i]) begin
          fails++; $display("[TB] FAIL push_fill_commit got lines %b data %h want %b data %h",
            {commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst}, commitQ[0].data,
            expLines(kind), vals[i]);
        end
        tests++;
        if (commitQ[0].hi != HOLD) begin
          fails++; $display("[TB] FAIL push_fill_width got %0d want %0d", commitQ[0].hi, HOLD);
        end
      end
      tests++;
      if (bus.depth !== 3'(i + 1)) begin
        fails++; $display("[TB] FAIL push_fill_depth got %0d want %0d", bus.depth, i + 1);
      end
      commitQ.delete();
    end
  endtask

  task automatic test_overflow();
    int kind;
    bit tmo;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      modelPress(4'b0001, kind);
      applyStimulus(4'b0001, 4'(i), 1, tmo);
    end
    commitQ.delete();
    modelPress(4'b0001, kind);
    applyStimulus(4'b0001, 4'hF, 2, tmo);
    tests++;
    if (tmo || commitQ.size() != 0) begin
      fails++; $display("[TB] FAIL overflow_commits got %0d (timeout %0d) want 0", commitQ.size(), tmo);
    end
    tests++;
    if ({bus.err_over, bus.err_under, bus.depth} !== {mErrO, mErrU, 3'(mDepth)}) begin
      fails++; $display("[TB] FAIL overflow_state got %b%b/%0d want %b%b/%0d",
        bus.err_over, bus.err_under, bus.depth, mErrO, mErrU, mDepth);
    end
    modelPress(4'b1000, kind);
    applyStimulus(4'b1000, 4'h0, 2, tmo);
    tests++;
    if ({bus.err_over, bus.err_under, bus.depth} !== {mErrO, mErrU, 3'(mDepth)}) begin
      fails++; $display("[TB] FAIL clear_errs got %b%b/%0d want %b%b/%0d",
        bus.err_over, bus.err_under, bus.depth, mErrO, mErrU, mDepth);
    end
    commitQ.delete();
  endtask

  task automatic test_underflow();
    logic [3:0] masks [3];
    int kind;
    bit tmo;
    masks[0] = 4'b0010; masks[1] = 4'b0001; masks[2] = 4'b0100;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      modelPress(masks[i], kind);
      applyStimulus(masks[i], 4'h7, 2, tmo);
      tests++;
      if (tmo || commitQ.size() != ((kind == K_NONE) ? 0 : 1)) begin
        fails++; $display("[TB] FAIL underflow_commits step %0d got %0d want %0d",
          i, commitQ.size(), (kind == K_NONE) ? 0 : 1);
      end
      tests++;
      if ({bus.err_over, bus.err_under, bus.depth} !== {mErrO, mErrU, 3'(mDepth)}) begin
        fails++; $display("[TB] FAIL underflow_state step %0d got %b%b/%0d want %b%b/%0d",
          i, bus.err_over, bus.err_under, bus.depth, mErrO, mErrU, mDepth);
      end
      commitQ.delete();
    end
  endtask

  task automatic test_exch_pop();
    logic [3:0] masks [4];
    int kind;
    bit tmo;
    masks[0] = 4'b0001; masks[1] = 4'b0001; masks[2] = 4'b0100; masks[3] = 4'b0010;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      modelPress(masks[i], kind);
      applyStimulus(masks[i], 4'(i + 6), 3, tmo);
      if (i >= 2) begin
        tests++;
        if (tmo || commitQ.size() != 1) begin
          fails++; $display("[TB] FAIL exch_pop_commits step %0d got %0d want 1", i, commitQ.size());
        end else if ({commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst} !== expLines(kind)) begin
          fails++; $display("[TB] FAIL exch_pop_lines step %0d got %b want %b", i,
            {commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst}, expLines(kind));
        end
        tests++;
        if ({bus.err_over, bus.err_under, bus.depth} !== {mErrO, mErrU, 3'(mDepth)}) begin
          fails++; $display("[TB] FAIL exch_pop_state step %0d got %b%b/%0d want %b%b/%0d",
            i, bus.err_over, bus.err_under, bus.depth, mErrO, mErrU, mDepth);
        end
      end
      commitQ.delete();
    end
  endtask

  task automatic test_priority_hold();
    int kind;
    bit tmo;
    applyReset();
    modelPress(4'b0001, kind);
    applyStimulus(4'b0001, 4'h1, 1, tmo);
    commitQ.delete();
    modelPress(4'b0011, kind);
    applyStimulus(4'b0011, 4'hC, 25, tmo);
    tests++;
    if (tmo || commitQ.size() != 1) begin
      fails++; $display("[TB] FAIL priority_commits got %0d want 1", commitQ.size());
    end else if ({commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst} !== expLines(kind) ||
                 commitQ[0].data !== 4'hC) begin
      fails++; $display("[TB] FAIL priority_commit got %b/%h want %b/c",
        {commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst}, commitQ[0].data, expLines(kind));
    end
    tests++;
    if (bus.depth !== 3'(mDepth)) begin
      fails++; $display("[TB] FAIL priority_depth got %0d want %0d", bus.depth, mDepth);
    end
    commitQ.delete();
  endtask

  task automatic test_reset_mid();
    int kind;
    int n;
    bit tmo;
    applyReset();
    for (int i = 0; i < 2; i++) begin
      modelPress(4'b0001, kind);
      applyStimulus(4'b0001, 4'h2, 1, tmo);
    end
    commitQ.delete();
    bus.sw = 4'h4;
    setButtons(4'b0001);
    n = 0;
    while (bus.stk_clk !== 1'b1 && n < 20) begin @(posedge ctl); #1; n++; end
    tests++;
    if (n >= 20) begin fails++; $display("[TB] FAIL reset_mid_strobe got no pulse want pulse"); end
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.stk_clk, bus.busy, bus.stk_rst, bus.depth} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      fails++; $display("[TB] FAIL reset_mid_outputs got clk%b busy%b rst%b d%0d want clk0 busy0 rst1 d0",
        bus.stk_clk, bus.busy, bus.stk_rst, bus.depth);
    end
    setButtons(4'b0000);
    repeat (2) @(posedge ctl);
    #1 rst = 1'b1;
    mDepth = 0; mErrO = 0; mErrU = 0;
    repeat (4) @(posedge ctl);
    #1;
    tests++;
    if (commitQ.size() != 0 || bus.depth !== 3'd0) begin
      fails++; $display("[TB] FAIL reset_mid_commit got %0d commits depth %0d want 0/0",
        commitQ.size(), bus.depth);
    end
    commitQ.delete();
  endtask

  task automatic test_clear();
    int kind;
    bit tmo;
    applyReset();
    for (int i = 0; i < 3; i++) begin
      modelPress(4'b0001, kind);
      applyStimulus(4'b0001, 4'(i), 1, tmo);
    end
    commitQ.delete();
    modelPress(4'b1000, kind);
    applyStimulus(4'b1000, 4'h0, 2, tmo);
    tests++;
    if (tmo || commitQ.size() != 1) begin
      fails++; $display("[TB] FAIL clear_commits got %0d want 1", commitQ.size());
    end else if ({commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst} !== expLines(kind)) begin
      fails++; $display("[TB] FAIL clear_lines got %b want %b",
        {commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst}, expLines(kind));
    end
    tests++;
    if ({bus.stk_rst, bus.depth} !== {1'b1, 3'(mDepth)}) begin
      fails++; $display("[TB] FAIL clear_after got rst%b d%0d want rst1 d%0d", bus.stk_rst, bus.depth, mDepth);
    end
    commitQ.delete();
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [3:0] val;
    int  kind;
    int  r;
    bit  tmo;
    applyReset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      mask = 4'b0001;
      else if (r <= 4) mask = 4'b0010;
      else if (r <= 6) mask = 4'b0100;
      else if (r == 7) mask = 4'b1000;
      else             mask = 4'($urandom_range(1, 15));
      val = 4'($urandom_range(0, 15));
      modelPress(mask, kind);
      applyStimulus(mask, val, $urandom_range(1, 6), tmo);
      tests++;
      if (tmo || commitQ.size() != ((kind == K_NONE) ? 0 : 1)) begin
        fails++; $display("[TB] FAIL random_commits iter %0d mask %b got %0d want %0d",
          i, mask, commitQ.size(), (kind == K_NONE) ? 0 : 1);
      end else if (kind != K_NONE) begin
        tests++;
        if ({commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst} !== expLines(kind) ||
            commitQ[0].hi != HOLD || (kind == K_PUSH && commitQ[0].data !== val)) begin
          fails++; $display("[TB] FAIL random_commit iter %0d got %b/%h/%0d want %b/%h/%0d", i,
            {commitQ[0].w2, commitQ[0].w1, commitQ[0].w3, commitQ[0].srst}, commitQ[0].data,
            commitQ[0].hi, expLines(kind), val, HOLD);
        end
      end
      tests++;
      if ({bus.err_over, bus.err_under, bus.depth} !== {mErrO, mErrU, 3'(mDepth)}) begin
        fails++; $display("[TB] FAIL random_state iter %0d got %b%b/%0d want %b%b/%0d",
          i, bus.err_over, bus.err_under, bus.depth, mErrO, mErrU, mDepth);
      end
      commitQ.delete();
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_overflow();
    test_underflow();
    test_exch_pop();
    test_priority_hold();
    test_reset_mid();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
